// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants and helpers for the DES subkey generator:
//   - width constants for the CD register, one half, and a subkey
//   - the 16-entry left-shift schedule S[n]
//   - the PC-2 selection table (FIPS 46 bit numbering, bit 1 = MSB)
//   - the key-schedule FSM state type
//   - per-half rotate helpers (rotation never crosses the C/D boundary)
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SK_W     = 48;
  localparam int N_ROUNDS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Element [i] holds S[i+1], so it can be indexed directly by round_idx.
  // Listed from S[16] down to S[1]; rounds 1, 2, 9 and 16 shift by one.
  localparam logic [N_ROUNDS-1:0][1:0] SHIFT_SCHED = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Entry [i] is the 1-based CD bit that feeds subkey bit i+1 (MSB first).
  localparam logic [0:SK_W-1][5:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Shift amounts are only ever 1 or 2.
  function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] x,
                                                  input logic [1:0]        s);
    return (s == 2'd1) ? {x[0], x[HALF_W-1:1]} : {x[1:0], x[HALF_W-1:2]};
  endfunction

  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                  input logic [1:0]        s);
    return (s == 2'd1) ? {x[HALF_W-2:0], x[HALF_W-1]}
                       : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd,
                                              input logic [1:0]      s);
    return {rotr_half(cd[CD_W-1:HALF_W], s), rotr_half(cd[HALF_W-1:0], s)};
  endfunction

  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd,
                                              input logic [1:0]      s);
    return {rotl_half(cd[CD_W-1:HALF_W], s), rotl_half(cd[HALF_W-1:0], s)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Purely combinational DES Permuted Choice 2: selects 48 of the 56 CD bits.
// Ports:
//   cd_i      in  56  C (cd_i[55:28]) and D (cd_i[27:0]); FIPS bit 1 = cd_i[55]
//   subkey_o  out 48  round subkey; FIPS bit 1 = subkey_o[47]
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output logic [SK_W-1:0] subkey_o
);

  // FIPS bit k of a 56-bit vector sits at index 56-k.
  for (genvar i = 0; i < SK_W; i++) begin : g_pc2
    assign subkey_o[SK_W-1-i] = cd_i[CD_W - int'(PC2_TAB[i])];
  end

endmodule

// File: rtl/des_subkey_rev_gen.sv
// -----------------------------------------------------------------------------
// des_subkey_rev_gen
// Sequential DES round-key generator. Streams the 16 subkeys one per accepted
// handshake, K16 first (decrypt order). The CD register is loaded from the
// PC-1 key and rotated right by S[n] after each accepted subkey; since the
// shifts total 28, C16D16 equals the loaded key, so K16 needs no pre-rotation.
//
// Optional build macro DES_KSCHED_ENC_EN: when defined, mode=0 at start
// selects encrypt order (K1 first, left rotations). When undefined, mode is
// ignored and the left-rotate path is not built.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   start         in   1  load key_in and begin a schedule (IDLE only)
//   key_in        in  56  PC-1 output, C = [55:28], D = [27:0]
//   mode          in   1  1 = decrypt order, 0 = encrypt order (macro only)
//   busy          out  1  schedule in progress
//   subkey_valid  out  1  subkey/round_idx hold a valid key
//   subkey_ready  in   1  consumer accepts the current key
//   subkey        out 48  PC-2 of the CD register
//   round_idx     out  4  DES round number minus 1
//   done          out  1  one-cycle pulse after the last handshake
//   dbg_state     out  1  current FSM state
//
// Handshake: a subkey transfers on every rising edge where subkey_valid and
// subkey_ready are both high. subkey_valid never depends on subkey_ready, and
// subkey/round_idx stay constant while valid is high and ready is low.
// -----------------------------------------------------------------------------
module des_subkey_rev_gen
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CD_W-1:0] key_in,
  input  logic            mode,
  output logic            busy,
  output logic            subkey_valid,
  input  logic            subkey_ready,
  output logic [SK_W-1:0] subkey,
  output logic [3:0]      round_idx,
  output logic            done,
  output state_e          dbg_state
);

  state_e          state_q;
  logic [CD_W-1:0] cd_q;
  logic [3:0]      idx_q;
  logic            done_q;

  logic            hs;
  logic            last_round;
  logic [CD_W-1:0] load_cd_d;
  logic [CD_W-1:0] step_cd_d;
  logic [3:0]      load_idx_d;
  logic [3:0]      step_idx_d;

  assign hs = (state_q == ISSUE) && subkey_ready;

`ifdef DES_KSCHED_ENC_EN
  logic enc_start;
  logic enc_q;

  assign enc_start = ~mode;

  // Encrypt order starts from C1D1 = rotl(C0D0, S[1]) with S[1] = 1, and
  // stepping from round n to n+1 uses S[n+1] = SHIFT_SCHED[idx+1].
  always_comb begin
    load_cd_d  = enc_start ? rotl_cd(key_in, 2'd1) : key_in;
    load_idx_d = enc_start ? 4'd0 : 4'd15;
    step_cd_d  = enc_q ? rotl_cd(cd_q, SHIFT_SCHED[idx_q + 4'd1])
                       : rotr_cd(cd_q, SHIFT_SCHED[idx_q]);
    step_idx_d = enc_q ? (idx_q + 4'd1) : (idx_q - 4'd1);
    last_round = enc_q ? (idx_q == 4'd15) : (idx_q == 4'd0);
  end
`else
  logic unused_mode;

  assign unused_mode = mode;

  always_comb begin
    load_cd_d  = key_in;
    load_idx_d = 4'd15;
    step_cd_d  = rotr_cd(cd_q, SHIFT_SCHED[idx_q]);
    step_idx_d = idx_q - 4'd1;
    last_round = (idx_q == 4'd0);
  end
`endif

  // Single FSM process. Without a handshake in ISSUE every register holds,
  // which is what keeps subkey/round_idx stable across a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
`ifdef DES_KSCHED_ENC_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cd_q    <= load_cd_d;
            idx_q   <= load_idx_d;
            state_q <= ISSUE;
`ifdef DES_KSCHED_ENC_EN
            enc_q   <= enc_start;
`endif
          end
        end
        ISSUE: begin
          if (hs) begin
            if (last_round) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cd_q  <= step_cd_d;
              idx_q <= step_idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey)
  );

  assign busy         = (state_q == ISSUE);
  assign subkey_valid = (state_q == ISSUE);
  assign round_idx    = idx_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_des_subkey_rev_gen.sv
module tb_des_subkey_rev_gen;
  import des_pkg::*;

  localparam logic [55:0] KAT_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [55:0] key_in = '0;
  logic        mode = 1'b1;
  logic        subkey_ready = 1'b0;
  logic        busy;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        done;
  state_e      dbg_state;

  always #5 clk = ~clk;

  des_subkey_rev_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key_in       (key_in),
    .mode         (mode),
    .busy         (busy),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  logic [51:0] exp_q[$];          // {round_idx, subkey}
  int          exp_done = 0;
  int          done_count = 0;
  int          hs_count = 0;
  logic [47:0] last_sub = '0;
  logic        stall_held = 1'b0;
  logic [51:0] held = '0;
  int          rdy_mode = 0;      // 0: ready high, 1: random with stalls

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int pc2_tab[48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                      23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [27:0] rol28(input logic [27:0] x, input int k);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < k; i++) y = {y[26:0], y[27]};
    return y;
  endfunction

  // K_n = PC2(C_n D_n), C_n = C0 rotated left by the running sum of S[1..n].
  function automatic logic [47:0] ref_key(input logic [55:0] k, input int n);
    int          tot;
    logic [55:0] cd;
    logic [47:0] o;
    tot = 0;
    for (int r = 1; r <= n; r++) tot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    cd = {rol28(k[55:28], tot), rol28(k[27:0], tot)};
    o = '0;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56 - pc2_tab[i]];
    return o;
  endfunction

  function automatic logic exp_enc(input logic m);
`ifdef DES_KSCHED_ENC_EN
    return ~m;
`else
    return 1'b0 & m;
`endif
  endfunction

  task automatic push_sched(input logic [55:0] k, input logic enc);
    if (enc) begin
      for (int n = 1; n <= 16; n++) exp_q.push_back({4'(n - 1), ref_key(k, n)});
    end else begin
      for (int n = 16; n >= 1; n--) exp_q.push_back({4'(n - 1), ref_key(k, n)});
    end
    exp_done++;
  endtask

  // ---------------- ready driver ----------------
  initial begin
    int stall_left;
    int r;
    stall_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        subkey_ready = 1'b1;
      end else if (stall_left > 0) begin
        subkey_ready = 1'b0;
        stall_left--;
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          stall_left = 4;
          subkey_ready = 1'b0;
        end else begin
          subkey_ready = (r > 3);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [51:0] e;
    if (rst_n) begin
      if (subkey_valid) begin
        if (stall_held) check("stall_hold", 64'({round_idx, subkey}), 64'(held));
        if (subkey_ready) begin
          hs_count++;
          stall_held = 1'b0;
          last_sub = subkey;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got %h expected none", {round_idx, subkey});
          end else begin
            e = exp_q.pop_front();
            check("key_stream", 64'({round_idx, subkey}), 64'(e));
          end
        end else begin
          stall_held = 1'b1;
          held = {round_idx, subkey};
        end
      end
      if (done) begin
        done_count++;
        check("done_valid_low", 64'({busy, subkey_valid}), 64'd0);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic issue_start(input logic [55:0] k, input logic m);
    int  t;
    logic enc;
    t = 0;
    while (busy && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("idle_before_start", 64'(busy), 64'd0);
    enc = exp_enc(m);
    start = 1'b1;
    key_in = k;
    mode = m;
    push_sched(k, enc);
    @(posedge clk);
    #1;
    start = 1'b0;
    key_in = {$urandom, $urandom};
    check("first_valid", 64'({busy, subkey_valid}), 64'b11);
    check("first_idx", 64'(round_idx), enc ? 64'd0 : 64'd15);
  endtask

  // Returns at posedge + 1 of the first cycle where done is high.
  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int t;
    t = 0;
    while (round_idx != idx && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("reach_idx", 64'(round_idx), 64'(idx));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic m;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, subkey_valid, done, round_idx, subkey}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known answer, ready high
    rdy_mode = 0;
    issue_start(KAT_KEY, 1'b1);
    check("kat_first", 64'(subkey), 64'(KAT_K16));
    base = hs_count;
    wait_done();
    check("kat_last", 64'(last_sub), 64'(KAT_K1));
    check("kat_count", 64'(hs_count - base), 64'd16);

    // Backpressure with the same key, back-to-back start at u+1
    rdy_mode = 1;
    issue_start(KAT_KEY, 1'b1);
    wait_done();
    check("bp_last", 64'(last_sub), 64'(KAT_K1));

    // Random keys and mode under random ready
    for (int i = 0; i < 5; i++) begin
      m = 1'($urandom_range(0, 1));
      issue_start({$urandom, $urandom}, m);
      wait_done();
    end

    // Start while busy and start coinciding with the final handshake
    rdy_mode = 0;
    issue_start(KAT_KEY, 1'b1);
    wait_idx(4'd9);
    start = 1'b1;
    key_in = 56'h123456789ABCDE;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idx(4'd0);
    start = 1'b1;
    key_in = 56'h0F0F0F0F0F0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("final_hs_done", 64'({done, subkey_valid}), 64'b10);
    repeat (3) @(posedge clk);
    #1;
    check("no_restart", 64'({busy, subkey_valid}), 64'd0);

    // Reset mid-stream after the 7th handshake
    issue_start(KAT_KEY, 1'b1);
    base = hs_count;
    for (int t = 0; t < 50 && hs_count < base + 7; t++) begin
      @(posedge clk);
      #1;
    end
    check("seven_hs", 64'(hs_count - base), 64'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({busy, subkey_valid, done, round_idx, subkey}), 64'd0);
    exp_q.delete();
    exp_done--;
    stall_held = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    issue_start(KAT_KEY, 1'b1);
    check("post_reset_first", 64'(subkey), 64'(KAT_K16));
    wait_done();
    check("post_reset_last", 64'(last_sub), 64'(KAT_K1));

`ifdef DES_KSCHED_ENC_EN
    rdy_mode = 0;
    issue_start(KAT_KEY, 1'b0);
    check("enc_first", 64'(subkey), 64'(KAT_K1));
    wait_done();
    check("enc_last", 64'(last_sub), 64'(KAT_K16));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_count), 64'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
